// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file slave: independent write/read FSMs over num_regs byte-strobed registers.
// Optional macro AXI4LITE_REG_SLAVE_PROT_EN rejects unprivileged (prot[0]=0) accesses with SLVERR.

module axi4lite_reg_slave_reg #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW/8-1:0] strb,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q,
    output logic          pulse
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= wr_en && (|strb);
            if (wr_en) begin
                for (int k = 0; k < DW/8; k++) begin
                    if (strb[k]) q[k*8 +: 8] <= data[k*8 +: 8];
                end
            end
        end
    end
endmodule

module axi4lite_reg_slave #(
    parameter int axi4_addr_size = 32,
    parameter int axi4_data_size = 64,
    parameter int num_regs       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_axi4lite_aw_valid,
    output logic                                 s_axi4lite_aw_ready,
    input  logic [axi4_addr_size-1:0]            s_axi4lite_aw_addr,
    input  logic [2:0]                           s_axi4lite_aw_prot,
    input  logic                                 s_axi4lite_w_valid,
    output logic                                 s_axi4lite_w_ready,
    input  logic [axi4_data_size-1:0]            s_axi4lite_w_data,
    input  logic [axi4_data_size/8-1:0]          s_axi4lite_w_strb,
    output logic                                 s_axi4lite_b_valid,
    input  logic                                 s_axi4lite_b_ready,
    output logic [1:0]                           s_axi4lite_b_resp,
    input  logic                                 s_axi4lite_ar_valid,
    output logic                                 s_axi4lite_ar_ready,
    input  logic [axi4_addr_size-1:0]            s_axi4lite_ar_addr,
    input  logic [2:0]                           s_axi4lite_ar_prot,
    output logic                                 s_axi4lite_r_valid,
    input  logic                                 s_axi4lite_r_ready,
    output logic [axi4_data_size-1:0]            s_axi4lite_r_data,
    output logic [1:0]                           s_axi4lite_r_resp,
    output logic [num_regs*axi4_data_size-1:0]   regs_q,
    output logic [num_regs-1:0]                  wr_pulse
);
    localparam int DW = axi4_data_size;
    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);
    localparam int IW = $clog2(num_regs);

    typedef struct packed {
        logic [axi4_addr_size-1:0] addr;
        logic [2:0]                prot;
    } addr_req_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } wdata_req_t;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    addr_req_t  aw_q;
    wdata_req_t w_q;
    logic [1:0] b_resp_q, r_resp_q;
    logic [DW-1:0] r_data_q;

    logic [num_regs-1:0][DW-1:0] regs;
    logic [num_regs-1:0]         reg_we;
    logic [num_regs-1:0]         pulse_int;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [axi4_addr_size-1:0] wr_addr;
    logic [2:0]                wr_prot;
    logic [DW-1:0]             wr_data;
    logic [SW-1:0]             wr_strb;
    logic [IW-1:0]             wr_idx, rd_idx;
    logic                      wr_ok, rd_ok;

    // Ready outputs depend only on state, so valid->ready never forms a combinational path.
    assign s_axi4lite_aw_ready = !rst && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
    assign s_axi4lite_w_ready  = !rst && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
    assign s_axi4lite_b_valid  = !rst && (wr_state == WR_RESP);
    assign s_axi4lite_ar_ready = !rst && (rd_state == RD_IDLE);
    assign s_axi4lite_r_valid  = !rst && (rd_state == RD_RESP);

    assign aw_hs = s_axi4lite_aw_valid && s_axi4lite_aw_ready;
    assign w_hs  = s_axi4lite_w_valid  && s_axi4lite_w_ready;
    assign b_hs  = s_axi4lite_b_valid  && s_axi4lite_b_ready;
    assign ar_hs = s_axi4lite_ar_valid && s_axi4lite_ar_ready;
    assign r_hs  = s_axi4lite_r_valid  && s_axi4lite_r_ready;

    // The half that arrived first comes from its holding register, the other half is live.
    assign wr_addr = (wr_state == WR_HAVE_AW) ? aw_q.addr : s_axi4lite_aw_addr;
    assign wr_prot = (wr_state == WR_HAVE_AW) ? aw_q.prot : s_axi4lite_aw_prot;
    assign wr_data = (wr_state == WR_HAVE_W)  ? w_q.data  : s_axi4lite_w_data;
    assign wr_strb = (wr_state == WR_HAVE_W)  ? w_q.strb  : s_axi4lite_w_strb;
    assign wr_idx  = wr_addr[LB +: IW];
    assign rd_idx  = s_axi4lite_ar_addr[LB +: IW];

`ifdef AXI4LITE_REG_SLAVE_PROT_EN
    assign wr_ok = ((wr_addr >> (LB + IW)) == '0) && wr_prot[0];
    assign rd_ok = ((s_axi4lite_ar_addr >> (LB + IW)) == '0) && s_axi4lite_ar_prot[0];
`else
    assign wr_ok = ((wr_addr >> (LB + IW)) == '0);
    assign rd_ok = ((s_axi4lite_ar_addr >> (LB + IW)) == '0);
`endif

    logic unused_prot;
    assign unused_prot = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, wr_prot};

    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_HAVE_W: if (aw_hs) begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_RESP: if (b_hs) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (r_hs)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        reg_we = '0;
        if (commit && wr_ok) reg_we[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            aw_q     <= '0;
            w_q      <= '0;
            b_resp_q <= 2'b00;
            r_resp_q <= 2'b00;
            r_data_q <= '0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (aw_hs) aw_q <= '{addr: s_axi4lite_aw_addr, prot: s_axi4lite_aw_prot};
            if (w_hs)  w_q  <= '{data: s_axi4lite_w_data, strb: s_axi4lite_w_strb};
            if (commit) b_resp_q <= wr_ok ? 2'b00 : 2'b10;
            // Reads sample regs before this edge's commit lands, giving the pre-write value.
            if (ar_hs) begin
                r_resp_q <= rd_ok ? 2'b00 : 2'b10;
                r_data_q <= rd_ok ? regs[rd_idx] : '0;
            end
        end
    end

    axi4lite_reg_slave_reg #(.DW(DW)) u_reg [num_regs-1:0] (
        .clk   (clk),
        .rst   (rst),
        .wr_en (reg_we),
        .strb  (wr_strb),
        .data  (wr_data),
        .q     (regs),
        .pulse (pulse_int)
    );

    assign s_axi4lite_b_resp = rst ? 2'b00 : b_resp_q;
    assign s_axi4lite_r_resp = rst ? 2'b00 : r_resp_q;
    assign s_axi4lite_r_data = rst ? '0 : r_data_q;
    assign regs_q            = rst ? '0 : regs;
    assign wr_pulse          = rst ? '0 : pulse_int;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized scoreboard bench for axi4lite_reg_slave (default 32-bit addr, 64-bit data, 16 regs).
module tb_axi4lite_reg_slave;
    localparam int N = 16;
    localparam int B = 8;

    logic clk = 0, rst = 1;
    logic aw_valid = 0, aw_ready, w_valid = 0, w_ready, b_valid, b_ready = 0;
    logic ar_valid = 0, ar_ready, r_valid, r_ready = 0;
    logic [31:0] aw_addr = 0, ar_addr = 0;
    logic [2:0]  aw_prot = 0, ar_prot = 0;
    logic [63:0] w_data = 0, r_data;
    logic [7:0]  w_strb = 0;
    logic [1:0]  b_resp, r_resp;
    logic [N*64-1:0] regs_q;
    logic [N-1:0] wr_pulse;

    always #5 clk = ~clk;

    axi4lite_reg_slave dut (
        .clk(clk), .rst(rst),
        .s_axi4lite_aw_valid(aw_valid), .s_axi4lite_aw_ready(aw_ready),
        .s_axi4lite_aw_addr(aw_addr), .s_axi4lite_aw_prot(aw_prot),
        .s_axi4lite_w_valid(w_valid), .s_axi4lite_w_ready(w_ready),
        .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb),
        .s_axi4lite_b_valid(b_valid), .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_resp(b_resp),
        .s_axi4lite_ar_valid(ar_valid), .s_axi4lite_ar_ready(ar_ready),
        .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
        .s_axi4lite_r_valid(r_valid), .s_axi4lite_r_ready(r_ready),
        .s_axi4lite_r_data(r_data), .s_axi4lite_r_resp(r_resp),
        .regs_q(regs_q), .wr_pulse(wr_pulse)
    );

    typedef struct packed { logic [1:0] resp; logic [N-1:0] pulse; } wexp_t;
    typedef struct packed { logic [1:0] resp; logic [63:0] data; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    logic [63:0] mdl [N];
    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic bit access_ok(input logic [31:0] a, input logic [2:0] p);
        bit ok = (a < N * B);
`ifdef AXI4LITE_REG_SLAVE_PROT_EN
        ok = ok && p[0];
`endif
        return ok;
    endfunction

    // Reference model: apply the write to the register array, queue the response it should produce.
    task automatic exp_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic [2:0] p);
        wexp_t e;
        e.pulse = '0;
        e.resp  = access_ok(a, p) ? 2'b00 : 2'b10;
        if (access_ok(a, p)) begin
            for (int k = 0; k < 8; k++)
                if (s[k]) mdl[a / B][k*8 +: 8] = d[k*8 +: 8];
            if (s != 0) e.pulse[a / B] = 1'b1;
        end
        wq.push_back(e);
    endtask

    task automatic exp_read(input logic [31:0] a, input logic [2:0] p);
        rexp_t e;
        e.resp = access_ok(a, p) ? 2'b00 : 2'b10;
        e.data = access_ok(a, p) ? mdl[a / B] : 64'h0;
        rq.push_back(e);
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                               input logic [2:0] p, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int t = 0;
        aw_addr = a; aw_prot = p; w_data = d; w_strb = s;
        while (!(aw_done && w_done)) begin
            if (t > 60) begin timeout("write_handshake"); break; end
            aw_valid = !aw_done && (t >= aw_dly);
            w_valid  = !w_done  && (t >= w_dly);
            @(negedge clk);
            if (aw_done) check("aw_ready_while_holding_aw", aw_ready, 0);
            if (w_done)  check("w_ready_while_holding_w", w_ready, 0);
            aw_fire = aw_valid && aw_ready;
            w_fire  = w_valid && w_ready;
            @(posedge clk); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            t++;
        end
        aw_valid = 0; w_valid = 0;
    endtask

    task automatic wait_b(input int hold);
        @(negedge clk);
        check("b_valid_latency", b_valid, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("b_hold_valid", b_valid, 1);
            check("b_hold_aw_ready", aw_ready, 0);
            check("b_hold_w_ready", w_ready, 0);
        end
        @(posedge clk); #1; b_ready = 1;
        @(posedge clk); #1; b_ready = 0;
        @(negedge clk);
        check("b_valid_after_hs", b_valid, 0);
        check("aw_ready_after_b", aw_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drive_read(input logic [31:0] a, input logic [2:0] p);
        bit fire = 0;
        int t = 0;
        ar_addr = a; ar_prot = p; ar_valid = 1;
        while (!fire) begin
            if (t > 60) begin timeout("ar_handshake"); break; end
            @(negedge clk);
            fire = ar_ready;
            @(posedge clk); #1;
            t++;
        end
        ar_valid = 0;
    endtask

    task automatic wait_r(input int hold);
        @(negedge clk);
        check("r_valid_latency", r_valid, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("r_hold_valid", r_valid, 1);
            check("r_hold_ar_ready", ar_ready, 0);
        end
        @(posedge clk); #1; r_ready = 1;
        @(posedge clk); #1; r_ready = 0;
        @(negedge clk);
        check("ar_ready_after_r", ar_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [2:0] p, input int aw_dly, input int w_dly, input int hold);
        exp_write(a, d, s, p);
        drive_write(a, d, s, p, aw_dly, w_dly);
        wait_b(hold);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int hold);
        exp_read(a, p);
        drive_read(a, p);
        wait_r(hold);
    endtask

    // Monitor: compares every response handshake and per-cycle wr_pulse against the queued expectations.
    initial begin : monitor
        logic bv_prev = 0;
        logic [N-1:0] exp_pulse;
        wexp_t we;
        rexp_t re;
        forever begin
            @(negedge clk);
            if (rst) begin
                bv_prev = 0;
                continue;
            end
            exp_pulse = '0;
            if (b_valid && !bv_prev) begin
                if (wq.size() == 0) timeout("b_valid_unexpected");
                else begin
                    exp_pulse = wq[0].pulse;
                    for (int i = 0; i < N; i++) check($sformatf("regs_q[%0d]", i), regs_q[i*64 +: 64], mdl[i]);
                end
            end
            check("wr_pulse", {48'h0, wr_pulse}, {48'h0, exp_pulse});
            if (b_valid && b_ready) begin
                if (wq.size() == 0) timeout("b_hs_unexpected");
                else begin
                    we = wq.pop_front();
                    check("b_resp", {62'h0, b_resp}, {62'h0, we.resp});
                end
            end
            if (r_valid && r_ready) begin
                if (rq.size() == 0) timeout("r_hs_unexpected");
                else begin
                    re = rq.pop_front();
                    check("r_resp", {62'h0, r_resp}, {62'h0, re.resp});
                    check("r_data", r_data, re.data);
                end
            end
            bv_prev = b_valid;
        end
    end

    initial begin : driver
        logic [31:0] a;
        logic [7:0] s;
        int r;
        for (int i = 0; i < N; i++) mdl[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_ar_ready", ar_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_regs_q", regs_q[63:0], 0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("idle_aw_ready", aw_ready, 1);
        check("idle_w_ready", w_ready, 1);
        check("idle_ar_ready", ar_ready, 1);
        for (int i = 0; i < N; i++) check("idle_regs_q", regs_q[i*64 +: 64], 0);
        @(posedge clk); #1;

        // Same-cycle write, then W three cycles ahead of AW with a low-half strobe.
        do_write(32'h08, 64'h1122334455667788, 8'hFF, 3'b001, 0, 0, 0);
        do_write(32'h08, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3'b001, 3, 0, 0);
        do_read(32'h08, 3'b001, 0);
        // Response back-pressure for 5 cycles.
        do_write(32'h20, 64'hDEADBEEF00000001, 8'hFF, 3'b001, 0, 2, 5);
        // Out of range, strobe zero.
        do_read(32'h80, 3'b001, 1);
        do_write(32'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'b001, 0, 0, 0);
        do_write(32'h30, 64'h1234, 8'h00, 3'b001, 1, 0, 0);

        // Write to reg2 commits on the same edge the read of reg2 handshakes.
        exp_read(32'h10, 3'b001);
        exp_write(32'h10, 64'd5, 8'hFF, 3'b001);
        aw_addr = 32'h10; aw_prot = 3'b001; w_data = 64'd5; w_strb = 8'hFF;
        ar_addr = 32'h10; ar_prot = 3'b001;
        aw_valid = 1; w_valid = 1; ar_valid = 1;
        @(negedge clk);
        check("conc_readies", {61'h0, aw_ready, w_ready, ar_ready}, 64'h7);
        @(posedge clk); #1;
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        @(negedge clk);
        check("conc_valids", {62'h0, b_valid, r_valid}, 64'h3);
        @(posedge clk); #1; b_ready = 1; r_ready = 1;
        @(posedge clk); #1; b_ready = 0; r_ready = 0;
        do_read(32'h10, 3'b001, 0);

        // Reset while holding an AW and a pending read response.
        aw_addr = 32'h18; aw_valid = 1; ar_addr = 32'h08; ar_valid = 1;
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        @(negedge clk);
        check("pre_rst_r_valid", r_valid, 1);
        check("pre_rst_aw_ready", aw_ready, 0);
        rst = 1;
        for (int i = 0; i < N; i++) mdl[i] = '0;
        @(negedge clk);
        check("mid_rst_b_valid", b_valid, 0);
        check("mid_rst_r_valid", r_valid, 0);
        check("mid_rst_ready", {61'h0, aw_ready, w_ready, ar_ready}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < N; i++) check("mid_rst_regs_q", regs_q[i*64 +: 64], 0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("post_rst_ready", {61'h0, aw_ready, w_ready, ar_ready}, 64'h7);
        check("post_rst_valids", {62'h0, b_valid, r_valid}, 0);
        @(posedge clk); #1;
        do_write(32'h18, 64'h0102030405060708, 8'hFF, 3'b001, 0, 1, 0);
        do_read(32'h18, 3'b001, 0);

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = $urandom_range(0, N*B - 1);
            else if (r < 9) a = $urandom_range(N*B, 2*N*B);
            else            a = $urandom;
            r = $urandom_range(0, 5);
            s = (r == 0) ? 8'h00 : (r < 3) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 2) != 0)
                do_write(a, {$urandom, $urandom}, s, 3'($urandom_range(0, 7)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
